// File: rtl/traffic_light_fsm.sv
// Main/side traffic light sequencer with an all-red pedestrian WALK phase.
// Tick-driven down-counter phase timer; lamps registered alongside Phase.
module traffic_light_fsm #(
  parameter int TW     = 8,
  parameter int MAIN_T = 6,
  parameter int YEL_T  = 2,
  parameter int SIDE_T = 4,
  parameter int EXT_T  = 3,
  parameter int WALK_T = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       Sensor,
  input  logic       WalkReq,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp,
  output logic       WalkReg_Reset,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    WALK   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Reload value is duration-1; a zero duration behaves as a single tick.
  function automatic logic [TW-1:0] dur_m1(input int t);
    return (t <= 1) ? '0 : TW'(t - 1);
  endfunction

  localparam logic [TW-1:0] MAIN_L = dur_m1(MAIN_T);
  localparam logic [TW-1:0] YEL_L  = dur_m1(YEL_T);
  localparam logic [TW-1:0] SIDE_L = dur_m1(SIDE_T);
  localparam logic [TW-1:0] EXT_L  = dur_m1(EXT_T);
  localparam logic [TW-1:0] WALK_L = dur_m1(WALK_T);

  state_t        state, state_next;
  logic [TW-1:0] cnt, cnt_next;
  logic          ext_used, ext_next;
  logic          wrr_next;
  logic          expire;
  logic [2:0]    main_next, side_next;
  logic          walk_next;

  assign expire = (cnt == '0) && tick;
  assign Phase  = state;

  always_comb begin
    state_next = state;
    cnt_next   = (tick && cnt != '0) ? cnt - TW'(1) : cnt;
    ext_next   = ext_used;
    wrr_next   = 1'b0;
    case (state)
      MAIN_G: if (expire) begin
        state_next = MAIN_Y;
        cnt_next   = YEL_L;
      end
      MAIN_Y: if (expire) begin
        if (WalkReq) begin
          state_next = WALK;
          cnt_next   = WALK_L;
          wrr_next   = 1'b1;
        end else begin
          state_next = SIDE_G;
          cnt_next   = SIDE_L;
          ext_next   = 1'b0;
        end
      end
      WALK: if (expire) begin
        state_next = SIDE_G;
        cnt_next   = SIDE_L;
        ext_next   = 1'b0;
      end
      SIDE_G: if (expire) begin
        if (Sensor && !ext_used) begin
          cnt_next = EXT_L;
          ext_next = 1'b1;
        end else begin
          state_next = SIDE_Y;
          cnt_next   = YEL_L;
        end
      end
      SIDE_Y: if (expire) begin
        state_next = MAIN_G;
        cnt_next   = MAIN_L;
      end
      default: begin
        state_next = MAIN_G;
        cnt_next   = MAIN_L;
        ext_next   = 1'b0;
      end
    endcase

    // Lamps decoded from the next state so they register on the same edge as Phase.
    main_next = RED;
    side_next = RED;
    walk_next = 1'b0;
    case (state_next)
      MAIN_G:  main_next = GRN;
      MAIN_Y:  main_next = YEL;
      WALK:    walk_next = 1'b1;
      SIDE_G:  side_next = GRN;
      SIDE_Y:  side_next = YEL;
      default: main_next = GRN;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state         <= MAIN_G;
      cnt           <= MAIN_L;
      ext_used      <= 1'b0;
      Main_Lights   <= GRN;
      Side_Lights   <= RED;
      Walk_Lamp     <= 1'b0;
      WalkReg_Reset <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      ext_used      <= ext_next;
      Main_Lights   <= main_next;
      Side_Lights   <= side_next;
      Walk_Lamp     <= walk_next;
      WalkReg_Reset <= wrr_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase lengths, WALK insertion,
// sensor extension, slow tick, async reset and request re-arm.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       Reset, tick, Sensor, WalkReq;
  logic [2:0] Main_Lights, Side_Lights, Phase;
  logic       Walk_Lamp, WalkReg_Reset;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_fsm #(
    .TW(8), .MAIN_T(4), .YEL_T(2), .SIDE_T(3), .EXT_T(2), .WALK_T(3)
  ) dut (
    .clk(clk), .Reset(Reset), .tick(tick), .Sensor(Sensor), .WalkReq(WalkReq),
    .Main_Lights(Main_Lights), .Side_Lights(Side_Lights), .Walk_Lamp(Walk_Lamp),
    .WalkReg_Reset(WalkReg_Reset), .Phase(Phase)
  );

  always #5 clk = ~clk;

  // {Main, Side, Walk} for each phase code
  function automatic logic [6:0] lamps(input int ph);
    case (ph)
      0:       return 7'b001_100_0;
      1:       return 7'b010_100_0;
      2:       return 7'b100_100_1;
      3:       return 7'b100_001_0;
      4:       return 7'b100_010_0;
      default: return 7'b000_000_0;
    endcase
  endfunction

  task automatic check(input string tag, input int ph, input logic wrr);
    logic [11:0] obs, exp;
    obs = {Phase, Main_Lights, Side_Lights, Walk_Lamp, WalkReg_Reset};
    exp = {ph[2:0], lamps(ph), wrr};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Checks one phase of n ticks, tick pulsed once every div cycles.
  task automatic do_phase(input string tag, input int ph, input int n, input int div);
    for (int i = 0; i < n * div; i++) begin
      tick = (div == 1) || (i % div == div - 1);
      check($sformatf("%s[%0d]", tag, i), ph, 1'((ph == 2) && (i == 0)));
      @(negedge clk);
    end
  endtask

  initial begin
    Reset = 1'b1; tick = 1'b1; Sensor = 1'b0; WalkReq = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 0, 1'b0);
    Reset = 1'b0;

    // 1: plain cycle, period 11
    do_phase("t1_main_g", 0, 4, 1);
    do_phase("t1_main_y", 1, 2, 1);
    do_phase("t1_side_g", 3, 3, 1);
    do_phase("t1_side_y", 4, 2, 1);

    // 2: walk request served after MAIN_Y
    WalkReq = 1'b1;
    do_phase("t2_main_g", 0, 4, 1);
    do_phase("t2_main_y", 1, 2, 1);
    do_phase("t2_walk",   2, 3, 1);
    WalkReq = 1'b0;
    do_phase("t2_side_g", 3, 3, 1);
    do_phase("t2_side_y", 4, 2, 1);

    // 3: sensor held high, single extension only
    Sensor = 1'b1;
    do_phase("t3_main_g", 0, 4, 1);
    do_phase("t3_main_y", 1, 2, 1);
    do_phase("t3_side_g", 3, 5, 1);
    do_phase("t3_side_y", 4, 2, 1);
    Sensor = 1'b0;

    // 6: request re-asserted during the clear pulse survives to the next round
    WalkReq = 1'b1;
    do_phase("t6_main_g",  0, 4, 1);
    do_phase("t6_main_y",  1, 2, 1);
    do_phase("t6_walk",    2, 3, 1);
    do_phase("t6_side_g",  3, 3, 1);
    do_phase("t6_side_y",  4, 2, 1);
    do_phase("t6_main_g2", 0, 4, 1);
    do_phase("t6_main_y2", 1, 2, 1);
    do_phase("t6_walk2",   2, 3, 1);
    WalkReq = 1'b0;
    do_phase("t6_side_g2", 3, 3, 1);
    do_phase("t6_side_y2", 4, 2, 1);

    // 4: tick once every 4 cycles
    do_phase("t4_main_g", 0, 4, 4);
    do_phase("t4_main_y", 1, 2, 4);
    do_phase("t4_side_g", 3, 3, 4);
    do_phase("t4_side_y", 4, 2, 4);

    // 5: asynchronous reset in the middle of WALK
    WalkReq = 1'b1;
    do_phase("t5_main_g", 0, 4, 1);
    do_phase("t5_main_y", 1, 2, 1);
    check("t5_walk_entry", 2, 1'b1);
    #2 Reset = 1'b1;
    #1 check("t5_async_reset", 0, 1'b0);
    @(negedge clk);
    check("t5_reset_hold", 0, 1'b0);
    Reset = 1'b0;
    WalkReq = 1'b0;
    do_phase("t5_main_g2", 0, 4, 1);
    do_phase("t5_main_y2", 1, 2, 1);
    do_phase("t5_side_g2", 3, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
